// File: rtl/dkong_audio_out.sv
// dkong_audio_out
//
// Audio output stage behind the game core's 8-bit sound mixer/limiter.
// The offset-binary mixer sample is box-decimated by DIV, passed through a
// one-pole low-pass, scaled by a 2-bit power-of-two gain with saturation,
// and delivered as a signed 16-bit PCM word with a one-cycle valid strobe.
//
// Optional build macro: AUDIO_DC_BLOCK_EN
//   When defined, a one-pole high-pass (DC block) sits between the low-pass
//   and the gain stage, adding one pipeline cycle of latency.
//
// Parameters
//   DIV        decimation ratio, power of 2, 2..1024
//   LOG2_DIV   log2(DIV), must match DIV
//   IIR_SHIFT  low-pass coefficient 2^-IIR_SHIFT, 0..6 (0 = bypass)
//   HP_SHIFT   DC-block coefficient 2^-HP_SHIFT (AUDIO_DC_BLOCK_EN only)
//
// Ports
//   W_CLK_12288M  in   1   system clock, rising edge
//   W_RESETn      in   1   asynchronous active-low reset
//   I_SND_DAT     in   8   mixer sample, offset binary, 0x80 = silence
//   I_MUTE        in   1   force input to silence
//   I_VOL         in   2   gain shift (x1/x2/x4/x8), sampled on the output edge
//   I_OVF_CLR     in   1   clears O_OVF (a simultaneous set wins)
//   O_PCM         out  16  signed PCM sample, held between strobes
//   O_PCM_VLD     out  1   one-cycle strobe, O_PCM updated
//   O_OVF         out  1   sticky flag, gain stage saturated

module dkong_audio_out #(
   parameter int DIV       = 256,
   parameter int LOG2_DIV  = 8,
   parameter int IIR_SHIFT = 2,
   parameter int HP_SHIFT  = 10
) (
   input  logic        W_CLK_12288M,
   input  logic        W_RESETn,
   input  logic [7:0]  I_SND_DAT,
   input  logic        I_MUTE,
   input  logic [1:0]  I_VOL,
   input  logic        I_OVF_CLR,
   output logic [15:0] O_PCM,
   output logic        O_PCM_VLD,
   output logic        O_OVF
);

   localparam int AW = 9 + LOG2_DIV;
   localparam logic [LOG2_DIV-1:0] CNT_LAST = LOG2_DIV'(DIV - 1);

   // decimator
   logic [LOG2_DIV-1:0]   cnt;
   logic signed [8:0]     s;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  acc_sum;
   logic                  cnt_last;
   logic signed [8:0]     m;
   logic                  stb_m;

   // low-pass
   logic signed [15:0]    x;
   logic signed [15:0]    y;
   logic signed [16:0]    diff;
   logic signed [16:0]    step;
   logic signed [15:0]    y_next;
   logic                  stb_y;

   // gain stage
   logic signed [15:0]    g_src;
   logic                  stb_g;
   logic signed [18:0]    g;
   logic                  sat_hi;
   logic                  sat_lo;
   logic [15:0]           pcm_next;

   always_comb begin
      s        = I_MUTE ? 9'sd0 : $signed({1'b0, I_SND_DAT} - 9'd128);
      acc_sum  = acc + {{LOG2_DIV{s[8]}}, s};
      cnt_last = (cnt == CNT_LAST);
   end

   // The top 9 bits of the period sum are the floor of sum / DIV.
   always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         cnt   <= '0;
         acc   <= '0;
         m     <= '0;
         stb_m <= 1'b0;
      end else begin
         cnt   <= cnt + 1'b1;
         stb_m <= cnt_last;
         if (cnt_last) begin
            m   <= acc_sum[AW-1:LOG2_DIV];
            acc <= '0;
         end else begin
            acc <= acc_sum;
         end
      end
   end

   // y moves a 2^-IIR_SHIFT fraction toward x; |x - y| always fits 17 bits
   // and y stays between old y and x, so the 16-bit result never wraps.
   always_comb begin
      x      = {m, 7'b0};
      diff   = {x[15], x} - {y[15], y};
      step   = diff >>> IIR_SHIFT;
      y_next = 16'(y + step);
   end

   always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         y     <= '0;
         stb_y <= 1'b0;
      end else begin
         stb_y <= stb_m;
         if (stb_m) begin
            y <= y_next;
         end
      end
   end

`ifdef AUDIO_DC_BLOCK_EN
   localparam int ZW = 16 + HP_SHIFT;

   // z tracks the DC level scaled by 2^HP_SHIFT; h is y with that level removed.
   logic signed [ZW-1:0]  z;
   logic signed [15:0]    zh;
   logic signed [16:0]    hd;
   logic signed [15:0]    h;
   logic signed [15:0]    h_next;
   logic                  stb_h;

   always_comb begin
      zh = z[ZW-1:HP_SHIFT];
      hd = {y[15], y} - {zh[15], zh};
      if (hd[16] != hd[15]) begin
         h_next = hd[16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
         h_next = hd[15:0];
      end
   end

   always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         z     <= '0;
         h     <= '0;
         stb_h <= 1'b0;
      end else begin
         stb_h <= stb_y;
         if (stb_y) begin
            z <= ZW'(z + hd);
            h <= h_next;
         end
      end
   end

   always_comb begin
      g_src = h;
      stb_g = stb_h;
   end
`else
   always_comb begin
      g_src = y;
      stb_g = stb_y;
   end
`endif

   // Gain in 19 bits: x8 of a full-scale 16-bit value needs 3 guard bits.
   always_comb begin
      g        = {{3{g_src[15]}}, g_src} << I_VOL;
      sat_hi   = !g[18] && (|g[17:15]);
      sat_lo   = g[18] && !(&g[17:15]);
      pcm_next = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : g[15:0]);
   end

   always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
      if (!W_RESETn) begin
         O_PCM     <= '0;
         O_PCM_VLD <= 1'b0;
         O_OVF     <= 1'b0;
      end else begin
         O_PCM_VLD <= stb_g;
         if (stb_g) begin
            O_PCM <= pcm_next;
         end
         if (stb_g && (sat_hi || sat_lo)) begin
            O_OVF <= 1'b1;
         end else if (I_OVF_CLR) begin
            O_OVF <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dkong_audio_out.sv
module tb_dkong_audio_out;

   localparam int DIV  = 256;
   localparam int LOGD = 8;
   localparam int IIR  = 2;
   localparam int HP   = 10;
`ifdef AUDIO_DC_BLOCK_EN
   localparam int LAT  = 3;
`else
   localparam int LAT  = 2;
`endif

   logic        W_CLK_12288M = 1'b0;
   logic        W_RESETn     = 1'b0;
   logic [7:0]  I_SND_DAT    = 8'h80;
   logic        I_MUTE       = 1'b0;
   logic [1:0]  I_VOL        = 2'd0;
   logic        I_OVF_CLR    = 1'b0;
   logic [15:0] O_PCM;
   logic        O_PCM_VLD;
   logic        O_OVF;

   dkong_audio_out #(
      .DIV(DIV), .LOG2_DIV(LOGD), .IIR_SHIFT(IIR), .HP_SHIFT(HP)
   ) dut (
      .W_CLK_12288M (W_CLK_12288M),
      .W_RESETn     (W_RESETn),
      .I_SND_DAT    (I_SND_DAT),
      .I_MUTE       (I_MUTE),
      .I_VOL        (I_VOL),
      .I_OVF_CLR    (I_OVF_CLR),
      .O_PCM        (O_PCM),
      .O_PCM_VLD    (O_PCM_VLD),
      .O_OVF        (O_OVF)
   );

   always #5 W_CLK_12288M = ~W_CLK_12288M;

   typedef struct {
      bit         rst;
      logic [7:0] dat;
      bit         mute;
      bit         alt;
      logic [1:0] vol;
      int         nper;
      bit         chk;
      int         exp_pcm;
      int         tol;
      bit         exp_ovf;
      bit         mono;
   } vec_t;

   typedef struct {
      int pcm;
      bit tag;
      int tpcm;
      int tol;
      bit tovf;
      bit mono;
   } exp_t;

   vec_t tbl [7];
   exp_t q [$];
   vec_t cur_v;
   bit   tag_next;

   int n_chk = 0;
   int n_fail = 0;
   int sum_m = 0;
   int cnt_m = 0;
   int y_m = 0;
   int z_m = 0;
   int edge_n = 0;
   int last_stb = -1;
   int hold_pcm = 0;
   int prev_pcm = 0;

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic reset_model();
      sum_m    = 0;
      cnt_m    = 0;
      y_m      = 0;
      z_m      = 0;
      edge_n   = 0;
      last_stb = -1;
      hold_pcm = 0;
      q.delete();
   endtask

   // Reference behaviour for one rising edge: box average, low-pass, gain.
   task automatic model_edge(input logic [7:0] d, input bit mu);
      int s, m, x, v, pcm;
      exp_t e;
      s = mu ? 0 : int'(d) - 128;
      sum_m += s;
      cnt_m++;
      if (cnt_m == DIV) begin
         m     = sum_m >>> LOGD;
         sum_m = 0;
         cnt_m = 0;
         x     = m * 128;
         y_m   = y_m + ((x - y_m) >>> IIR);
`ifdef AUDIO_DC_BLOCK_EN
         begin
            int zh;
            zh  = z_m >>> HP;
            v   = sat16(y_m - zh);
            z_m = z_m + y_m - zh;
         end
`else
         v = y_m;
`endif
         pcm    = sat16(v * (1 << int'(I_VOL)));
         e.pcm  = pcm;
         e.tag  = tag_next;
         e.tpcm = cur_v.exp_pcm;
         e.tol  = cur_v.tol;
         e.tovf = cur_v.exp_ovf;
         e.mono = cur_v.mono;
         q.push_back(e);
      end
   endtask

   task automatic check_out();
      int act;
      exp_t e;
      act = int'($signed(O_PCM));
      if (O_PCM_VLD) begin
         if (last_stb < 0) check("first_strobe_edge", edge_n, DIV + LAT);
         else              check("strobe_period", edge_n - last_stb, DIV);
         last_stb = edge_n;
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got pcm %0d, expected no strobe", act);
         end else begin
            e = q.pop_front();
            check("pcm", act, e.pcm);
`ifndef AUDIO_DC_BLOCK_EN
            if (e.tag) begin
               n_chk++;
               if (act - e.tpcm > e.tol || e.tpcm - act > e.tol) begin
                  n_fail++;
                  $display("FAIL table_pcm: got %0d, expected %0d +/- %0d", act, e.tpcm, e.tol);
               end
               check("table_ovf", int'(O_OVF), int'(e.tovf));
            end
            if (e.mono) begin
               n_chk++;
               if (!(act < prev_pcm && act >= 0)) begin
                  n_fail++;
                  $display("FAIL mute_decay: got %0d, expected below %0d and >= 0", act, prev_pcm);
               end
            end
`endif
         end
         prev_pcm = act;
         hold_pcm = act;
      end else begin
         check("pcm_hold", act, hold_pcm);
      end
   endtask

   task automatic cyc(input logic [7:0] d, input bit mu);
      I_SND_DAT = d;
      I_MUTE    = mu;
      @(posedge W_CLK_12288M);
      edge_n++;
      model_edge(d, mu);
      @(negedge W_CLK_12288M);
      check_out();
   endtask

   task automatic do_reset(input logic [1:0] vol);
      repeat (LAT + 1) cyc(I_SND_DAT, I_MUTE);
      check("queue_drained", q.size(), 0);
      #2 W_RESETn = 1'b0;
      @(posedge W_CLK_12288M);
      @(posedge W_CLK_12288M);
      I_VOL = vol;
      @(negedge W_CLK_12288M);
      W_RESETn = 1'b1;
      reset_model();
   endtask

   task automatic apply(input vec_t v);
      logic [7:0] d;
      if (v.rst) do_reset(v.vol);
      cur_v = v;
      for (int p = 0; p < v.nper; p++) begin
         tag_next = v.chk && (p == v.nper - 1);
         for (int c = 0; c < DIV; c++) begin
            d = (v.alt && c[0]) ? ~v.dat : v.dat;
            cyc(d, v.mute);
         end
      end
      tag_next = 1'b0;
   endtask

   initial begin
      //        rst  dat    mu alt vol  nper chk exp_pcm  tol ovf mono
      tbl[0] = '{1, 8'h80, 0, 0, 2'd0, 3,  1, 0,      0, 0, 0};
      tbl[1] = '{0, 8'hFF, 0, 0, 2'd0, 4,  1, 11112,  0, 0, 0};
      tbl[2] = '{0, 8'hFF, 0, 0, 2'd0, 40, 1, 16256,  3, 0, 0};
      tbl[3] = '{0, 8'hFF, 1, 0, 2'd0, 6,  1, 2891,   0, 0, 1};
      tbl[4] = '{1, 8'h00, 0, 0, 2'd3, 2,  1, -32768, 0, 1, 0};
      tbl[5] = '{0, 8'h80, 0, 0, 2'd3, 4,  1, -18144, 0, 1, 0};
      tbl[6] = '{0, 8'h00, 0, 1, 2'd0, 1,  1, -32,    0, 0, 0};
      cur_v    = tbl[0];
      tag_next = 1'b0;

      #1;
      check("reset_pcm", int'(O_PCM), 0);
      check("reset_vld", int'(O_PCM_VLD), 0);
      check("reset_ovf", int'(O_OVF), 0);

      for (int i = 0; i < 6; i++) apply(tbl[i]);

      // Sticky flag survives silence, then a lone clear drops it.
      repeat (4) cyc(8'h80, 1'b0);
      check("ovf_sticky", int'(O_OVF), 1);
      I_OVF_CLR = 1'b1;
      cyc(8'h80, 1'b0);
      I_OVF_CLR = 1'b0;
      check("ovf_clear", int'(O_OVF), 0);
      repeat (DIV - 5) cyc(8'h80, 1'b0);

      // Clear on the same edge as a saturating strobe: set wins.
      repeat (DIV) cyc(8'h00, 1'b0);
      repeat (LAT - 1) cyc(8'h00, 1'b0);
      I_OVF_CLR = 1'b1;
      cyc(8'h00, 1'b0);
      I_OVF_CLR = 1'b0;
      check("clr_edge_strobe", int'(O_PCM_VLD), 1);
      check("ovf_set_wins", int'(O_OVF), 1);
      check("sat_pcm", int'($signed(O_PCM)), -32768);

      // Asynchronous reset in the middle of a period.
      repeat (100 - LAT) cyc(8'h00, 1'b0);
      check("queue_before_async_rst", q.size(), 0);
      #2 W_RESETn = 1'b0;
      #1;
      check("async_rst_pcm", int'(O_PCM), 0);
      check("async_rst_vld", int'(O_PCM_VLD), 0);
      check("async_rst_ovf", int'(O_OVF), 0);
      @(posedge W_CLK_12288M);
      @(posedge W_CLK_12288M);
      I_VOL = 2'd0;
      @(negedge W_CLK_12288M);
      W_RESETn = 1'b1;
      reset_model();

      apply(tbl[6]);
      repeat (LAT + 1) cyc(8'h80, 1'b0);
      check("queue_final", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dkong_audio_out.md
Name: dkong_audio_out

Overview:
- Audio output stage directly downstream of the game core's 8-bit sound mixer/limiter.
- Takes the unsigned offset-binary mixer sample, which changes at up to 12.288 MHz.
- Box-decimates it by DIV (48 kHz at default), applies a one-pole low-pass and a volume gain with saturation.
- Delivers a signed 16-bit PCM word with a one-cycle valid strobe to the platform audio path.

Parameters:
DIV, 256, decimation ratio; power of 2, 2..1024
LOG2_DIV, 8, log2(DIV); must match DIV
IIR_SHIFT, 2, low-pass coefficient 2^-IIR_SHIFT, 0..6 (0 = bypass)
HP_SHIFT, 10, DC-block coefficient 2^-HP_SHIFT (only with AUDIO_DC_BLOCK_EN)

Ports:
W_CLK_12288M  in  1  system clock, 12.288 MHz, rising edge
W_RESETn  in  1  reset, asynchronous, active-low
I_SND_DAT  in  8  mixer sample, offset binary, 0x80 = silence
I_MUTE  in  1  1 = input forced to silence
I_VOL  in  2  gain: output = filtered << I_VOL (x1/x2/x4/x8)
I_OVF_CLR  in  1  clears O_OVF
O_PCM  out  16  signed PCM sample
O_PCM_VLD  out  1  one-cycle strobe, O_PCM updated
O_OVF  out  1  sticky flag, gain stage saturated

Behaviour:
Reset:
- W_RESETn low asynchronously clears cnt, acc, m, y, DC state, O_PCM=0, O_PCM_VLD=0, O_OVF=0.
- Reset mid-accumulation discards the partial sum; no strobe is produced for that period.

Input conversion:
- s = {1'b0,I_SND_DAT} - 9'd128, 9-bit signed.
- I_MUTE=1 forces s=0, so filter state decays naturally with no step.

Decimator:
- cnt (LOG2_DIV bits) increments every clock and wraps DIV-1 -> 0.
- acc is (9+LOG2_DIV)-bit signed. When cnt != DIV-1: acc <= acc + s.
- When cnt == DIV-1 (edge T): m <= (acc + s) >>> LOG2_DIV (arithmetic, floor, 9-bit signed); acc <= 0.
- Each period therefore sums exactly DIV samples.

Pipeline:
- T+1: x = m <<< 7 (16-bit signed, range -16384..16256); y <= y + ((x - y) >>> IIR_SHIFT), with the difference held in 17 bits. y is a convex combination, so it cannot overflow.
- T+2: g = y <<< I_VOL in 19 bits, saturated to [-32768, 32767].
  - O_PCM <= sat(g); O_PCM_VLD <= 1 for exactly one cycle.
  - If saturation occurred, O_OVF <= 1.
- Latency: sample at edge T appears at edge T+2. Strobe period is exactly DIV cycles.
- First strobe follows rising edge DIV+2 after reset release; the first edge after release has cnt=0.
- I_VOL is sampled only at the T+2 edge.

O_OVF:
- Sticky; cleared by I_OVF_CLR.
- A set and a clear on the same edge leave the flag set.

Between strobes:
- O_PCM holds its value; O_PCM_VLD is 0.

Optional Feature:
AUDIO_DC_BLOCK_EN
- Defined: one-pole high-pass inserted between the IIR and the gain stage.
  - State z is (16+HP_SHIFT)-bit signed; zh = z >>> HP_SHIFT.
  - On the edge after y updates: z <= z + y - zh; h <= sat16(y - zh).
  - The gain stage uses h instead of y.
  - Adds one pipeline stage: latency T+3, first strobe after edge DIV+3.
- Undefined: the stage is absent; timing is as described in Behaviour.

Test Plan:
1. I_SND_DAT=0x80 constant, I_VOL=0 -> O_PCM=0 on every strobe; strobes 256 cycles apart; first strobe after edge 258; O_OVF=0.
2. I_SND_DAT=0xFF constant, I_VOL=0, IIR_SHIFT=2 -> m=127, x=16256; O_PCM sequence 4064, 7112, 9398, 11112, converging to 16256 (+/-3).
3. I_SND_DAT=0x00 constant, I_VOL=3 -> y=-4096,-7168 -> O_PCM=-32768 from the first strobe, O_OVF=1. Pulse I_OVF_CLR with I_SND_DAT=0x80 after y decays -> O_OVF=0. I_OVF_CLR concurrent with saturation -> O_OVF stays 1.
4. I_SND_DAT alternating 0x00/0xFF each cycle, cnt=0 with 0x00 -> sum=-128, m=-1, x=-128; first O_PCM=-32.
5. Steady state of test 2, then I_MUTE=1 with I_SND_DAT=0xFF -> next m=0; O_PCM decays monotonically toward 0 (each step 3/4 of the previous value).
6. Assert W_RESETn low at cnt=100 -> O_PCM=0, O_PCM_VLD=0, O_OVF=0 immediately, without waiting for a clock edge; after release, the next strobe follows edge 258. With AUDIO_DC_BLOCK_EN and constant 0xFF, O_PCM decays toward 0 after the initial rise.
